// File: rtl/tt_mux_pkg.sv
// Shared types and constants for the multi-project tile mux wrapper.
package tt_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  // Bit position of the project rst_n inside the packed input bus.
  localparam int IW_RSTN_BIT = 1;

  localparam int DEF_N_PROJ    = 4;
  localparam int DEF_SEL_W     = 2;
  localparam int DEF_IW_W      = 18;
  localparam int DEF_OW_W      = 24;
  localparam int DEF_DRAIN_CYC = 2;
  localparam int DEF_RST_HOLD  = 8;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/tt_mux_seq_cnt.sv
// Loadable down-counter; done is high while the count sits at zero.
module tt_mux_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tt_proj_mux_wrapper.sv
// Hosts N_PROJ project tiles; select handshake drives drain/enable/reset sequencing.
// Define TT_MUX_OUT_SYNC_EN for a second register stage on the ow_out path.
module tt_proj_mux_wrapper
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ    = DEF_N_PROJ,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int IW_W      = DEF_IW_W,
  parameter int OW_W      = DEF_OW_W,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC,
  parameter int RST_HOLD  = DEF_RST_HOLD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SEL_W-1:0]       sel_req,
  input  logic                   sel_valid,
  output logic                   sel_ready,
  output logic                   sel_err,
  input  logic [IW_W-1:0]        iw_in,
  output logic [OW_W-1:0]        ow_out,
  output logic [IW_W-1:0]        iw_o,
  output logic [N_PROJ-1:0]      ena_o,
  input  logic [N_PROJ*OW_W-1:0] ow_i,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   busy
);

  localparam int CW = cnt_width(DRAIN_CYC, RST_HOLD);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic [IW_W-1:0]  iw_q, iw_d;
  logic [OW_W-1:0]  ow_sel, ow1_q, ow1_d;
  logic             accept, req_ok, cnt_load, cnt_done;
  logic [CW-1:0]    cnt_val;

  assign sel_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign busy      = (state_q == ST_DRAIN) || (state_q == ST_HOLD);
  assign accept    = sel_valid & sel_ready;
  assign req_ok    = ({1'b0, sel_req} < (SEL_W+1)'(N_PROJ));

  tt_mux_seq_cnt #(.W(CW)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .done_o     (cnt_done)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    err_d    = err_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        // Re-selecting the current project is legal and forces a fresh reset.
        if (accept) begin
          if (req_ok) begin
            state_d  = ST_DRAIN;
            sel_d    = sel_req;
            cnt_load = 1'b1;
            cnt_val  = CW'(DRAIN_CYC - 1);
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_done) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = CW'(RST_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (cnt_done) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ow_sel = '0;
    for (int k = 0; k < N_PROJ; k++)
      if (sel_q == SEL_W'(k)) ow_sel = ow_i[k*OW_W +: OW_W];
  end

  always_comb begin
    ena_o = '0;
    if (state_q == ST_HOLD || state_q == ST_RUN)
      for (int k = 0; k < N_PROJ; k++)
        ena_o[k] = (sel_q == SEL_W'(k));
  end

  // Gate on the upcoming state so iw_o/ow_out line up with the state they belong to.
  always_comb begin
    iw_d = iw_in;
    if (state_d != ST_RUN) iw_d[IW_RSTN_BIT] = 1'b0;
    ow1_d = (state_q == ST_RUN && state_d == ST_RUN) ? ow_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      err_q   <= 1'b0;
      iw_q    <= '0;
      ow1_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      iw_q    <= iw_d;
      ow1_q   <= ow1_d;
    end
  end

`ifdef TT_MUX_OUT_SYNC_EN
  logic [OW_W-1:0] ow2_q;

  always_ff @(posedge clk) begin
    if (rst) ow2_q <= '0;
    else     ow2_q <= ow1_q;
  end

  assign ow_out = ow2_q;
`else
  assign ow_out = ow1_q;
`endif

  assign iw_o       = iw_q;
  assign active_sel = sel_q;
  assign sel_err    = err_q;

endmodule

// File: tb/tb_tt_proj_mux_wrapper.sv
// Bench for tt_proj_mux_wrapper: table vectors, directed corner sequences, random vs model.
module tb_tt_proj_mux_wrapper;

  localparam int NP = 4, SW = 2, IWW = 18, OWW = 24, DC = 2, RH = 8;
`ifdef TT_MUX_OUT_SYNC_EN
  localparam int OLAT = 2;
`else
  localparam int OLAT = 1;
`endif

  logic              clk, rst;
  logic [SW-1:0]     sel_req;
  logic              sel_valid, sel_ready, sel_err, busy;
  logic [IWW-1:0]    iw_in, iw_o;
  logic [OWW-1:0]    ow_out;
  logic [NP-1:0]     ena_o;
  logic [NP*OWW-1:0] ow_i;
  logic [SW-1:0]     active_sel;

  logic [SW-1:0]     sel_req3, active3;
  logic              sel_valid3, sel_ready3, sel_err3, busy3;
  logic [IWW-1:0]    iw_o3;
  logic [OWW-1:0]    ow_out3;
  logic [2:0]        ena3;
  logic [3*OWW-1:0]  ow_i3;

  assign ow_i3 = ow_i[3*OWW-1:0];

  tt_proj_mux_wrapper #(.N_PROJ(NP), .SEL_W(SW), .IW_W(IWW), .OW_W(OWW),
                        .DRAIN_CYC(DC), .RST_HOLD(RH)) u_dut (
    .clk(clk), .rst(rst), .sel_req(sel_req), .sel_valid(sel_valid),
    .sel_ready(sel_ready), .sel_err(sel_err), .iw_in(iw_in), .ow_out(ow_out),
    .iw_o(iw_o), .ena_o(ena_o), .ow_i(ow_i), .active_sel(active_sel), .busy(busy)
  );

  tt_proj_mux_wrapper #(.N_PROJ(3), .SEL_W(SW), .IW_W(IWW), .OW_W(OWW),
                        .DRAIN_CYC(DC), .RST_HOLD(RH)) u_dut3 (
    .clk(clk), .rst(rst), .sel_req(sel_req3), .sel_valid(sel_valid3),
    .sel_ready(sel_ready3), .sel_err(sel_err3), .iw_in(iw_in), .ow_out(ow_out3),
    .iw_o(iw_o3), .ena_o(ena3), .ow_i(ow_i3), .active_sel(active3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are read at the next falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; sel_valid = 1'b0; sel_valid3 = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] req;
    logic [3:0] ena;
    logic       bsy;
    logic       rdy;
    logic       iw1;
  } vec_t;

  vec_t vt[12];

  // Reference model: the switch timeline is kept as "cycle of first DRAIN cycle".
  int  cyc, t_acc, msel;
  bit  m_idle, merr;
  logic [IWW-1:0] e_iw;
  logic [OWW-1:0] e_ow1, e_ow2;

  function automatic bit m_run();
    return !m_idle && (cyc - t_acc) >= DC + RH;
  endfunction
  function automatic bit m_busy();
    return !m_idle && (cyc - t_acc) < DC + RH;
  endfunction
  function automatic bit m_ena_on();
    return !m_idle && (cyc - t_acc) >= DC;
  endfunction

  initial begin
    vt[0]  = '{1'b1, 2'd2, 4'b0000, 1'b1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 2'd0, 4'b0000, 1'b1, 1'b0, 1'b0};
    for (int i = 2; i < 10; i++) vt[i] = '{1'b0, 2'd0, 4'b0100, 1'b1, 1'b0, 1'b0};
    vt[10] = '{1'b0, 2'd0, 4'b0100, 1'b0, 1'b1, 1'b1};
    vt[11] = '{1'b0, 2'd0, 4'b0100, 1'b0, 1'b1, 1'b1};

    sel_req = '0; sel_req3 = '0; iw_in = '1; ow_i = '1;
    do_reset();
    chk("rst_ena", ena_o, 0);
    chk("rst_ready", sel_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", sel_err, 0);
    chk("rst_active", active_sel, 0);
    chk("rst_iw", iw_o, 0);
    chk("rst_ow", ow_out, 0);

    // First switch to project 2 from IDLE.
    for (int i = 0; i < 12; i++) begin
      sel_valid = vt[i].v; sel_req = vt[i].req;
      step(1);
      chk($sformatf("tbl%0d_ena", i), ena_o, vt[i].ena);
      chk($sformatf("tbl%0d_busy", i), busy, vt[i].bsy);
      chk($sformatf("tbl%0d_ready", i), sel_ready, vt[i].rdy);
      chk($sformatf("tbl%0d_iw1", i), iw_o[1], vt[i].iw1);
    end
    chk("tbl_iw_pass", iw_o, 18'h3FFFF);

    // Output slice selection while running on project 2.
    ow_i = {24'hFFFFFF, 24'hA5C33C, 24'hFFFFFF, 24'hFFFFFF};
    step(OLAT);
    chk("run2_ow", ow_out, 24'hA5C33C);

    // Switch 2 -> 0: output blanks from DRAIN entry until one latency after RUN.
    ow_i = {24'hFFFFFF, 24'hA5C33C, 24'hFFFFFF, 24'h123456};
    sel_valid = 1'b1; sel_req = 2'd0;
    step(1);
    sel_valid = 1'b0;
    chk("sw0_k1_ena", ena_o, 0);
`ifndef TT_MUX_OUT_SYNC_EN
    chk("sw0_k1_ow", ow_out, 0);
`endif
    for (int k = 2; k <= 11; k++) begin
      step(1);
      chk($sformatf("sw0_k%0d_ena", k), ena_o, (k >= 3) ? 4'b0001 : 4'b0000);
      chk($sformatf("sw0_k%0d_ow", k), ow_out, 0);
    end
    step(OLAT);
    chk("sw0_ow_live", ow_out, 24'h123456);

    // Reset in the middle of HOLD.
    sel_valid = 1'b1; sel_req = 2'd1;
    step(1);
    sel_valid = 1'b0;
    step(6);
    chk("hold_ena", ena_o, 4'b0010);
    chk("hold_iw1", iw_o[1], 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mrst_ena", ena_o, 0);
    chk("mrst_ready", sel_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_active", active_sel, 0);
    chk("mrst_iw", iw_o, 0);
    chk("mrst_ow", ow_out, 0);

    // Held request is only accepted once the first switch reaches RUN.
    sel_valid = 1'b1; sel_req = 2'd2;
    step(1);
    sel_req = 2'd1;
    for (int k = 2; k <= 10; k++) begin
      step(1);
      chk($sformatf("held_k%0d_busy", k), busy, 1);
      chk($sformatf("held_k%0d_act", k), active_sel, 2);
    end
    step(1);
    chk("held_run_ena", ena_o, 4'b0100);
    chk("held_run_ready", sel_ready, 1);
    step(1);
    chk("held_resw_busy", busy, 1);
    chk("held_resw_act", active_sel, 1);
    chk("held_resw_ena", ena_o, 0);
    sel_valid = 1'b0;
    step(10);
    chk("held_final_ena", ena_o, 4'b0010);

    // Out-of-range request on a 3-project instance.
    sel_valid3 = 1'b1; sel_req3 = 2'd2;
    step(1);
    sel_valid3 = 1'b0;
    step(10);
    chk("p3_run_ena", ena3, 3'b100);
    sel_valid3 = 1'b1; sel_req3 = 2'd3;
    step(1);
    sel_valid3 = 1'b0;
    chk("p3_err", sel_err3, 1);
    chk("p3_err_ena", ena3, 0);
    chk("p3_err_busy", busy3, 0);
    chk("p3_err_ready", sel_ready3, 1);
    chk("p3_err_act", active3, 2);
    chk("p3_err_iw1", iw_o3[1], 0);
`ifndef TT_MUX_OUT_SYNC_EN
    chk("p3_err_ow", ow_out3, 0);
`endif
    sel_valid3 = 1'b1; sel_req3 = 2'd1;
    step(1);
    sel_valid3 = 1'b0;
    step(10);
    chk("p3_after_ena", ena3, 3'b010);
    chk("p3_after_act", active3, 1);
    chk("p3_after_err", sel_err3, 1);

    // Random traffic against the timeline model.
    do_reset();
    cyc = 0; t_acc = 0; msel = 0; m_idle = 1'b1; merr = 1'b0;
    e_iw = '0; e_ow1 = '0; e_ow2 = '0;
    for (int n = 0; n < 1500; n++) begin
      bit cur_run, cur_rdy, nxt_run;
      chk("rnd_ena", ena_o, m_ena_on() ? (4'b0001 << msel) : 4'b0000);
      chk("rnd_busy", busy, m_busy());
      chk("rnd_ready", sel_ready, !m_busy());
      chk("rnd_active", active_sel, msel);
      chk("rnd_err", sel_err, merr);
      chk("rnd_iw", iw_o, e_iw);
`ifdef TT_MUX_OUT_SYNC_EN
      chk("rnd_ow", ow_out, e_ow2);
`else
      chk("rnd_ow", ow_out, e_ow1);
`endif
      rst       = ($urandom_range(0, 99) == 0);
      sel_valid = ($urandom_range(0, 7) == 0);
      sel_req   = SW'($urandom_range(0, NP - 1));
      iw_in     = IWW'($urandom);
      ow_i      = {$urandom, $urandom, $urandom};
      cur_run = m_run();
      cur_rdy = !m_busy();
      cyc++;
      if (rst) begin
        m_idle = 1'b1; msel = 0; merr = 1'b0;
        e_iw = '0; e_ow1 = '0; e_ow2 = '0;
      end else begin
        if (sel_valid && cur_rdy) begin
          if (int'(sel_req) < NP) begin
            t_acc = cyc; msel = int'(sel_req); m_idle = 1'b0;
          end else begin
            merr = 1'b1; m_idle = 1'b1;
          end
        end
        nxt_run = m_run();
        e_iw = iw_in;
        if (!nxt_run) e_iw[1] = 1'b0;
        e_ow2 = e_ow1;
        e_ow1 = (cur_run && nxt_run) ? ow_i[msel*OWW +: OWW] : '0;
      end
      step(1);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
